// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op encodings, FSM states, default width.
// Shift support (and the SHIFT state) exists only when ALU_NBIT_SEQ_SHIFT_EN is defined.
package alu_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SLT  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_SRA  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ALU_NBIT_SEQ_SHIFT_EN
    ST_SHIFT = 2'd2,
`endif
    ST_DONE  = 2'd1
  } state_e;

  function automatic logic is_shift_op(input op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_nbit_core.sv
// Combinational AND/OR/ADD/SLT datapath with carry, overflow, zero and error flags.
// Any op it does not implement returns result 0 with err set.
module alu_nbit_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainvert,
  input  logic             bnegate,
  input  op_e              op,
  output logic [WIDTH-1:0] result_c,
  output logic             cout_c,
  output logic             zero_c,
  output logic             overflow_c,
  output logic             err_c
);

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] b_m;
  logic [WIDTH:0]   sum_c;
  logic             cin_msb_c;
  logic             ovf_c;

  assign a_m   = ainvert ? ~a : a;
  assign b_m   = bnegate ? ~b : b;
  assign sum_c = {1'b0, a_m} + {1'b0, b_m} + (WIDTH+1)'(bnegate);

  // Carry into the MSB recovered from the MSB sum bit.
  assign cin_msb_c = a_m[WIDTH-1] ^ b_m[WIDTH-1] ^ sum_c[WIDTH-1];
  assign ovf_c     = cin_msb_c ^ sum_c[WIDTH];

  always_comb begin
    result_c   = '0;
    cout_c     = 1'b0;
    overflow_c = 1'b0;
    err_c      = 1'b0;
    case (op)
      OP_AND: result_c = a_m & b_m;
      OP_OR:  result_c = a_m | b_m;
      OP_ADD: begin
        result_c   = sum_c[WIDTH-1:0];
        cout_c     = sum_c[WIDTH];
        overflow_c = ovf_c;
      end
      OP_SLT: begin
        result_c   = WIDTH'(sum_c[WIDTH-1] ^ ovf_c);
        cout_c     = sum_c[WIDTH];
        overflow_c = ovf_c;
      end
      default: err_c = 1'b1;
    endcase
  end

  assign zero_c = (result_c == '0);

endmodule

// File: rtl/alu_nbit_seq.sv
// Sequential ALU with valid/ready handshakes; shifts run one bit per cycle.
// Define ALU_NBIT_SEQ_SHIFT_EN to build SLL/SRL/SRA; otherwise they behave as the reserved op.
module alu_nbit_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ainvert,
  input  logic             bnegate,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             err_q, err_d;

  op_e              op_c;
  logic [WIDTH-1:0] core_result_c;
  logic             core_cout_c;
  logic             core_zero_c;
  logic             core_overflow_c;
  logic             core_err_c;

  assign op_c = op_e'(op);

  alu_nbit_core #(.WIDTH(WIDTH)) u_core (
    .a          (a),
    .b          (b),
    .ainvert    (ainvert),
    .bnegate    (bnegate),
    .op         (op_c),
    .result_c   (core_result_c),
    .cout_c     (core_cout_c),
    .zero_c     (core_zero_c),
    .overflow_c (core_overflow_c),
    .err_c      (core_err_c)
  );

`ifdef ALU_NBIT_SEQ_SHIFT_EN
  logic [SHW-1:0]   cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [SHW-1:0]   shamt_c;
  logic [WIDTH-1:0] shifted_c;

  assign shamt_c = b[SHW-1:0];

  // One-bit step of the shift held in result_q.
  always_comb begin
    shifted_c = result_q;
    case (op_q)
      OP_SLL:  shifted_c = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted_c = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shifted_c = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shifted_c = result_q;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    cout_d     = cout_q;
    zero_d     = zero_q;
    overflow_d = overflow_q;
    err_d      = err_q;
`ifdef ALU_NBIT_SEQ_SHIFT_EN
    cnt_d      = cnt_q;
    op_d       = op_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_DONE;
          result_d   = core_result_c;
          cout_d     = core_cout_c;
          zero_d     = core_zero_c;
          overflow_d = core_overflow_c;
          err_d      = core_err_c;
`ifdef ALU_NBIT_SEQ_SHIFT_EN
          op_d = op_c;
          if (is_shift_op(op_c)) begin
            result_d   = a;
            cout_d     = 1'b0;
            overflow_d = 1'b0;
            err_d      = 1'b0;
            zero_d     = (a == '0);
            if (shamt_c != '0) begin
              state_d = ST_SHIFT;
              cnt_d   = shamt_c;
              zero_d  = 1'b0;
            end
          end
`endif
        end
      end
`ifdef ALU_NBIT_SEQ_SHIFT_EN
      ST_SHIFT: begin
        result_d = shifted_c;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          state_d = ST_DONE;
          zero_d  = (shifted_c == '0);
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      cout_q     <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef ALU_NBIT_SEQ_SHIFT_EN
      cnt_q      <= '0;
      op_q       <= OP_AND;
`endif
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      zero_q     <= zero_d;
      overflow_q <= overflow_d;
      err_q      <= err_d;
`ifdef ALU_NBIT_SEQ_SHIFT_EN
      cnt_q      <= cnt_d;
      op_q       <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Self-checking bench for alu_nbit_seq (WIDTH=16) against an arithmetic reference model.
// Adapts its expectations to whether ALU_NBIT_SEQ_SHIFT_EN is defined.
module tb_alu_nbit_seq;

  localparam int unsigned W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ainvert;
  logic          bnegate;
  logic [2:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout;
  logic          zero;
  logic          overflow;
  logic          err;

  int checks = 0;
  int errors = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ainvert   (ainvert),
    .bnegate   (bnegate),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero),
    .overflow  (overflow),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic on the operands.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mai, input logic mbn, input logic [2:0] mop,
                                output logic [W-1:0] r, output logic c, output logic z,
                                output logic v, output logic e, output int lat);
    logic [W-1:0] ap, bp;
    longint ua, ub, sa, sb, us, ss;
    int k;
    ap = mai ? ~ma : ma;
    bp = mbn ? ~mb : mb;
    ua = longint'(ap);
    ub = longint'(bp);
    sa = (ua >= 32768) ? ua - 65536 : ua;
    sb = (ub >= 32768) ? ub - 65536 : ub;
    us = ua + ub + longint'(mbn);
    ss = sa + sb + longint'(mbn);
    k  = int'(mb[3:0]);
    r = '0; c = 1'b0; v = 1'b0; e = 1'b0; lat = 1;
    case (mop)
      3'd0: r = ap & bp;
      3'd1: r = ap | bp;
      3'd2, 3'd3: begin
        c = (us >= 65536);
        v = (ss < -32768) || (ss > 32767);
        if (mop == 3'd2) r = W'(us);
        else             r = (ss < 0) ? W'(1) : W'(0);
      end
`ifdef ALU_NBIT_SEQ_SHIFT_EN
      3'd4: begin r = ma << k; lat = (k == 0) ? 1 : k + 1; end
      3'd5: begin r = ma >> k; lat = (k == 0) ? 1 : k + 1; end
      3'd6: begin r = W'($signed(ma) >>> k); lat = (k == 0) ? 1 : k + 1; end
`endif
      default: e = 1'b1;
    endcase
    z = (r == '0);
  endfunction

  // Issues one operation, scrambles inputs while busy, returns outputs at first out_valid.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tai,
                        input logic tbn, input logic [2:0] top,
                        output logic [W-1:0] r, output logic c, output logic z,
                        output logic v, output logic e, output int lat);
    @(negedge clk);
    a = ta; b = tb_v; ainvert = tai; bnegate = tbn; op = top;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
    ainvert = 1'($urandom); bnegate = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    r = result; c = cout; z = zero; v = overflow; e = err;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h exp 0000", result); end
    checks++; if ({cout, zero, overflow, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {cout, zero, overflow, err});
    end
  endtask

  task automatic test_arith();
    logic [W-1:0] r; logic c, z, v, e; int lat;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 3'd2, r, c, z, v, e, lat);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL add_ovf_result got %h exp 8000", r); end
    checks++; if ({c, z, v, e} !== 4'b0010) begin errors++; $display("FAIL add_ovf_flags got %b exp 0010", {c, z, v, e}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d exp 1", lat); end
    run_op(16'h1234, 16'h1234, 1'b0, 1'b1, 3'd2, r, c, z, v, e, lat);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL sub_result got %h exp 0000", r); end
    checks++; if ({c, z, v, e} !== 4'b1100) begin errors++; $display("FAIL sub_flags got %b exp 1100", {c, z, v, e}); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 3'd3, r, c, z, v, e, lat);
    checks++; if (r !== 16'h0001) begin errors++; $display("FAIL slt_result got %h exp 0001", r); end
    run_op(16'hABCD, 16'h1234, 1'b0, 1'b0, 3'd7, r, c, z, v, e, lat);
    checks++; if ({r, c, z, v, e} !== {16'h0000, 4'b0101}) begin
      errors++; $display("FAIL rsvd got %h/%b exp 0000/0101", r, {c, z, v, e});
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] r; logic c, z, v, e; int lat;
`ifdef ALU_NBIT_SEQ_SHIFT_EN
    run_op(16'h0001, 16'd15, 1'b0, 1'b0, 3'd4, r, c, z, v, e, lat);
    checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sll15_result got %h exp 8000", r); end
    checks++; if (lat !== 16) begin errors++; $display("FAIL sll15_latency got %0d exp 16", lat); end
    run_op(16'h8000, 16'd4, 1'b1, 1'b0, 3'd6, r, c, z, v, e, lat);
    checks++; if (r !== 16'hF800) begin errors++; $display("FAIL sra4_result got %h exp F800", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL sra4_latency got %0d exp 5", lat); end
    run_op(16'h00F0, 16'h0010, 1'b0, 1'b0, 3'd5, r, c, z, v, e, lat);
    checks++; if (r !== 16'h00F0 || lat !== 1 || {c, z, v, e} !== 4'b0000) begin
      errors++; $display("FAIL srl0 got %h lat %0d flags %b exp 00F0 lat 1 flags 0000", r, lat, {c, z, v, e});
    end
`else
    run_op(16'h0001, 16'd3, 1'b0, 1'b0, 3'd4, r, c, z, v, e, lat);
    checks++; if (r !== 16'h0000) begin errors++; $display("FAIL sll_off_result got %h exp 0000", r); end
    checks++; if ({z, e} !== 2'b11) begin errors++; $display("FAIL sll_off_flags got %b exp 11", {z, e}); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL sll_off_latency got %0d exp 1", lat); end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] r, xr, ra, rb; logic c, z, v, e, xc, xz, xv, xe, rai, rbn;
    logic [2:0] rop; int lat, xlat, sel;
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: ra = 16'h0000;
        1: ra = 16'h7FFF;
        2: ra = 16'h8000;
        3: ra = 16'hFFFF;
        default: ra = W'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rai = 1'($urandom); rbn = 1'($urandom); rop = 3'($urandom);
      model(ra, rb, rai, rbn, rop, xr, xc, xz, xv, xe, xlat);
      run_op(ra, rb, rai, rbn, rop, r, c, z, v, e, lat);
      checks++; if (r !== xr || {c, z, v, e} !== {xc, xz, xv, xe} || lat !== xlat) begin
        errors++;
        $display("FAIL rand_%0d op %0d a %h b %h ai %b bn %b got %h/%b/%0d exp %h/%b/%0d",
                 i, rop, ra, rb, rai, rbn, r, {c, z, v, e}, lat, xr, {xc, xz, xv, xe}, xlat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] xr; logic xc, xz, xv, xe; int xlat, n;
    model(16'hFFFF, 16'h0001, 1'b0, 1'b0, 3'd2, xr, xc, xz, xv, xe, xlat);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; ainvert = 1'b0; bnegate = 1'b0; op = 3'd2;
    in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 64);
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== xr ||
                    {cout, zero, overflow, err} !== {xc, xz, xv, xe}) begin
        errors++;
        $display("FAIL bp_hold_%0d got v%b r%b %h/%b exp v1 r0 %h/%b", i, out_valid, in_ready,
                 result, {cout, zero, overflow, err}, xr, {xc, xz, xv, xe});
      end
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom); op = 3'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release got in_ready %b out_valid %b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r; logic c, z, v, e; int lat;
    @(negedge clk);
    a = 16'h0001; b = 16'd12; ainvert = 1'b0; bnegate = 1'b0; op = 3'd4;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifdef ALU_NBIT_SEQ_SHIFT_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_shift_valid got %b exp 0", out_valid); end
`else
    checks++; if (out_valid !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL mid_done got valid %b err %b exp 1 1", out_valid, err);
    end
`endif
    #2 rst = 1'b1;
    #1;
    checks++; if ({result, cout, zero, overflow, err, out_valid} !== {16'h0000, 5'b00000}) begin
      errors++; $display("FAIL async_reset got %h/%b exp 0000/00000", result, {cout, zero, overflow, err, out_valid});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", in_ready); end
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 3'd2, r, c, z, v, e, lat);
    checks++; if (r !== 16'h0005 || lat !== 1) begin
      errors++; $display("FAIL post_reset_add got %h lat %0d exp 0005 lat 1", r, lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; ainvert = 1'b0; bnegate = 1'b0; op = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_arith();
    test_shift();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nbit_seq.md
ALU_NBIT_SEQ -- requirements
Module: alu_nbit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width in bits (legal: power of two, 4..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have ports a, b  input  WIDTH  operands; b[SHW-1:0] is the shift amount for shift ops.
REQ-008 SHALL have ports ainvert, bnegate  input  1  invert a / invert b with carry-in = bnegate.
REQ-009 SHALL have port op  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 SLL, 101 SRL, 110 SRA, 111 reserved.
REQ-010 SHALL have port out_valid  output  1  result fields valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have ports result WIDTH, cout 1, zero 1, overflow 1, err 1, all outputs, registered.

Function
REQ-013 SHALL accept an operation on a rising edge where in_valid && in_ready, latching a, b, ainvert, bnegate, op.
REQ-014 SHALL use FSM states IDLE, SHIFT, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-015 SHALL, for AND/OR/ADD/SLT/reserved and for shifts with shift amount 0, go IDLE->DONE on acceptance; out_valid in the cycle after acceptance.
REQ-016 SHALL, for shifts with amount k>0, go IDLE->SHIFT with counter=k, shift one bit per cycle, enter DONE after k SHIFT cycles; out_valid first in cycle k+1 after acceptance.
REQ-017 SHALL compute a' = ainvert ? ~a : a, b' = bnegate ? ~b : b; AND = a'&b', OR = a'|b', ADD = a'+b'+bnegate (WIDTH bits).
REQ-018 SHALL set cout = carry out of MSB and overflow = carry-in(MSB) XOR carry-out(MSB) for ADD and SLT; 0 for all other ops.
REQ-019 SHALL return SLT result = {WIDTH-1 zeros, sign(ADD) XOR overflow}.
REQ-020 SHALL for SLL/SRL/SRA shift a (ainvert ignored) left zero-fill / right zero-fill / right sign-fill.
REQ-021 SHALL set zero = (result == 0), computed on the final result, for every op.
REQ-022 SHALL for op 111 return result 0, zero 1, err 1; err = 0 for all implemented ops.
REQ-023 SHALL hold DONE and all result fields stable while out_ready = 0; DONE->IDLE on out_valid && out_ready.
REQ-024 SHALL ignore in_valid and input changes while not in IDLE (maximum throughput one op per two cycles).

Reset
REQ-025 SHALL on rst asynchronously force state IDLE, result 0, cout 0, zero 0, overflow 0, err 0, shift counter 0, regardless of state (including mid-SHIFT); in_ready = 1 from the first cycle after rst deasserts.

Configuration
REQ-026 SHALL compile shift support only when macro ALU_NBIT_SEQ_SHIFT_EN is defined.
REQ-027 SHALL, without ALU_NBIT_SEQ_SHIFT_EN, omit the SHIFT state and counter and treat ops 100/101/110 exactly as op 111 (result 0, zero 1, err 1, one-cycle latency).

Structure
REQ-028 SHALL place op encodings, FSM state enum and the default WIDTH constant in shared package alu_pkg.
REQ-029 SHALL implement AND/OR/ADD/SLT/flag logic in combinational sub-module alu_nbit_core (parameter WIDTH), instantiated once.

Verification (WIDTH=16, ALU_NBIT_SEQ_SHIFT_EN defined unless stated)
REQ-030 SHALL test ADD a=0x7FFF b=0x0001 -> result 0x8000, overflow 1, cout 0, zero 0, out_valid 1 cycle after acceptance.
REQ-031 SHALL test SUB (op ADD, bnegate 1) a=0x1234 b=0x1234 -> result 0x0000, zero 1, cout 1, overflow 0; SLT bnegate 1 a=0x8000 b=0x0001 -> result 0x0001.
REQ-032 SHALL test SLL a=0x0001 b=15 -> result 0x8000 with out_valid first in cycle 16 after acceptance; SRA a=0x8000 b=4 -> 0xF800 in cycle 5.
REQ-033 SHALL test backpressure: out_ready held 0 for 10 cycles in DONE -> result/flags unchanged, in_ready 0, new in_valid ignored; release -> IDLE next cycle.
REQ-034 SHALL test rst asserted during SLL b=12 at SHIFT cycle 5 -> all outputs 0 immediately, in_ready 1 after release, next ADD 0x0002+0x0003 -> 0x0005.
REQ-035 SHALL test build without ALU_NBIT_SEQ_SHIFT_EN: op 100 a=0x0001 b=3 -> result 0, zero 1, err 1, out_valid 1 cycle after acceptance.
